// File: rtl/time_set_controller.sv
// time_set_controller: button-driven field edit sequencer with auto-repeat strobes and idle timeout
module time_set_controller #(
    parameter int unsigned HOLD_CYCLES    = 25_000_000,
    parameter int unsigned REPEAT_CYCLES  = 6_250_000,
    parameter int unsigned TIMEOUT_CYCLES = 500_000_000,
    parameter int unsigned CNT_W          = 29
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       butt_change,
    input  logic       butt_increase,
    input  logic       butt_decrease,
    input  logic       sw_mode,
    output logic [2:0] field_sel,
    output logic       inc_pulse,
    output logic       dec_pulse,
    output logic       run_en,
    output logic       exit_pulse,
    output logic       led10,
    output logic       led14,
    output logic       led17
);
    typedef enum logic [1:0] {RUN, F0, F1, F2} state_t;
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    // button vectors: bit 0 change, bit 1 increase, bit 2 decrease
    logic [2:0] s1, s2, prev, held, edge_v;
    state_t state, state_nx;
    logic group, group_nx, edit;
    logic inc_nx, dec_nx, exit_nx;
    logic [CNT_W-1:0] hold_cnt, hold_nx, rep_cnt, rep_nx, idle_cnt, idle_nx;
    assign held   = ~s2;
    assign edge_v = ~s2 & prev;
    assign edit   = state != RUN;
    always_ff @(posedge clk) begin
        if (rst) begin
            s1         <= '1;
            s2         <= '1;
            prev       <= '1;
            state      <= RUN;
            group      <= 1'b0;
            hold_cnt   <= '0;
            rep_cnt    <= '0;
            idle_cnt   <= '0;
            inc_pulse  <= 1'b0;
            dec_pulse  <= 1'b0;
            exit_pulse <= 1'b0;
        end else begin
            s1         <= {butt_decrease, butt_increase, butt_change};
            s2         <= s1;
            prev       <= s2;
            state      <= state_nx;
            group      <= group_nx;
            hold_cnt   <= hold_nx;
            rep_cnt    <= rep_nx;
            idle_cnt   <= idle_nx;
            inc_pulse  <= inc_nx;
            dec_pulse  <= dec_nx;
            exit_pulse <= exit_nx;
        end
    end
    always_comb begin
        state_nx = state;
        group_nx = group;
        hold_nx  = '0;
        rep_nx   = '0;
        idle_nx  = '0;
        inc_nx   = 1'b0;
        dec_nx   = 1'b0;
        if (edge_v[0]) begin
            state_nx = state_t'(state + 2'd1);
            group_nx = edit ? group : sw_mode;
        end else if (edit && held == 3'b000 && idle_cnt == IDLE_LAST) begin
            state_nx = RUN;
        end else if (edit) begin
            idle_nx = held != 3'b000 ? '0 : idle_cnt == CNT_MAX ? idle_cnt : idle_cnt + ONE;
            // exactly one of inc/dec held; both held keeps everything cleared
            if (held[1] ^ held[2]) begin
                if (hold_cnt != HOLD_MAX) begin
                    hold_nx = hold_cnt + ONE;
                    inc_nx  = edge_v[1];
                    dec_nx  = edge_v[2];
                end else begin
                    hold_nx = hold_cnt;
                    rep_nx  = rep_cnt == REP_LAST ? '0 : rep_cnt + ONE;
                    inc_nx  = held[1] && rep_cnt == '0;
                    dec_nx  = held[2] && rep_cnt == '0;
                end
            end
        end
        exit_nx = edit && state_nx == RUN;
    end
    assign field_sel = edit ? {1'b0, state} + (group ? 3'd3 : 3'd0) : 3'd0;
    assign run_en    = state == RUN;
    assign led10     = state == F0;
    assign led14     = state == F1;
    assign led17     = state == F2;
endmodule

// File: tb/tb_time_set_controller.sv
// tb_time_set_controller: table-driven and directed checks of the edit sequencer
module tb_time_set_controller;
    logic clk = 0, rst = 1, bc = 1, bi = 1, bd = 1, sw = 0;
    logic [2:0] field_sel;
    logic inc_pulse, dec_pulse, run_en, exit_pulse, led10, led14, led17;
    int inc_n = 0, dec_n = 0, exit_n = 0, checks = 0, errors = 0;

    time_set_controller #(
        .HOLD_CYCLES(10), .REPEAT_CYCLES(4), .TIMEOUT_CYCLES(50), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .butt_change(bc), .butt_increase(bi), .butt_decrease(bd),
        .sw_mode(sw), .field_sel(field_sel), .inc_pulse(inc_pulse), .dec_pulse(dec_pulse),
        .run_en(run_en), .exit_pulse(exit_pulse), .led10(led10), .led14(led14), .led17(led17)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (inc_pulse) inc_n++;
        if (dec_pulse) dec_n++;
        if (exit_pulse) exit_n++;
    end

    typedef struct {
        logic c, i, d, m;
        int n, fs, run, leds, inc, dec, ex;
    } vec_t;
    vec_t tbl[25];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int leds();
        return int'({led10, led14, led17});
    endfunction

    task automatic press_change();
        bc = 0;
        tick(5);
        bc = 1;
        tick(5);
    endtask

    initial begin
        // c i d m  n  fs run leds inc dec ex ; leds = {led10,led14,led17}
        tbl[0]  = '{1, 1, 1, 0, 3,  0, 1, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 1, 0, 5,  1, 0, 4, 0, 0, 0};
        tbl[2]  = '{1, 1, 1, 0, 5,  1, 0, 4, 0, 0, 0};
        tbl[3]  = '{0, 1, 1, 0, 5,  2, 0, 2, 0, 0, 0};
        tbl[4]  = '{1, 1, 1, 0, 5,  2, 0, 2, 0, 0, 0};
        tbl[5]  = '{0, 1, 1, 0, 5,  3, 0, 1, 0, 0, 0};
        tbl[6]  = '{1, 1, 1, 0, 5,  3, 0, 1, 0, 0, 0};
        tbl[7]  = '{0, 1, 1, 0, 5,  0, 1, 0, 0, 0, 1};
        tbl[8]  = '{1, 1, 1, 0, 5,  0, 1, 0, 0, 0, 1};
        tbl[9]  = '{0, 1, 1, 1, 5,  4, 0, 4, 0, 0, 1};
        tbl[10] = '{1, 1, 1, 0, 5,  4, 0, 4, 0, 0, 1};
        tbl[11] = '{1, 0, 1, 0, 10, 4, 0, 4, 1, 0, 1};
        tbl[12] = '{1, 1, 1, 0, 5,  4, 0, 4, 1, 0, 1};
        tbl[13] = '{1, 1, 0, 0, 5,  4, 0, 4, 1, 1, 1};
        tbl[14] = '{1, 1, 1, 0, 5,  4, 0, 4, 1, 1, 1};
        tbl[15] = '{0, 1, 1, 0, 5,  5, 0, 2, 1, 1, 1};
        tbl[16] = '{1, 1, 1, 0, 5,  5, 0, 2, 1, 1, 1};
        tbl[17] = '{1, 0, 0, 0, 20, 5, 0, 2, 1, 1, 1};
        tbl[18] = '{1, 1, 1, 0, 5,  5, 0, 2, 1, 1, 1};
        tbl[19] = '{0, 1, 1, 0, 5,  6, 0, 1, 1, 1, 1};
        tbl[20] = '{1, 1, 1, 0, 5,  6, 0, 1, 1, 1, 1};
        tbl[21] = '{0, 1, 1, 0, 5,  0, 1, 0, 1, 1, 2};
        tbl[22] = '{1, 1, 1, 0, 5,  0, 1, 0, 1, 1, 2};
        tbl[23] = '{1, 0, 1, 0, 5,  0, 1, 0, 1, 1, 2};
        tbl[24] = '{1, 1, 1, 0, 5,  0, 1, 0, 1, 1, 2};

        rst = 1;
        tick(3);
        chk("reset field_sel", int'(field_sel), 0);
        chk("reset run_en", int'(run_en), 1);
        chk("reset leds", leds(), 0);
        chk("reset strobes", int'({inc_pulse, dec_pulse, exit_pulse}), 0);
        rst = 0;

        for (int k = 0; k < 25; k++) begin
            bc = tbl[k].c;
            bi = tbl[k].i;
            bd = tbl[k].d;
            sw = tbl[k].m;
            tick(tbl[k].n);
            chk($sformatf("vec%0d field_sel", k), int'(field_sel), tbl[k].fs);
            chk($sformatf("vec%0d run_en", k), int'(run_en), tbl[k].run);
            chk($sformatf("vec%0d leds", k), leds(), tbl[k].leds);
            chk($sformatf("vec%0d inc_count", k), inc_n, tbl[k].inc);
            chk($sformatf("vec%0d dec_count", k), dec_n, tbl[k].dec);
            chk($sformatf("vec%0d exit_count", k), exit_n, tbl[k].ex);
        end

        // exact latency of an edge strobe: high only after the third edge
        press_change();
        chk("latency field_sel", int'(field_sel), 1);
        bi = 0;
        tick(1);
        chk("latency edge1", int'(inc_pulse), 0);
        tick(1);
        chk("latency edge2", int'(inc_pulse), 0);
        tick(1);
        chk("latency edge3", int'(inc_pulse), 1);
        tick(1);
        chk("latency edge4", int'(inc_pulse), 0);
        bi = 1;
        tick(5);
        chk("latency inc_count", inc_n, 2);

        // auto-repeat: 30 held cycles -> edge + repeats at 10,14,18,22,26
        press_change();
        chk("repeat field_sel", int'(field_sel), 2);
        bd = 0;
        tick(30);
        bd = 1;
        tick(10);
        chk("repeat dec_count", dec_n, 7);
        tick(10);
        chk("repeat after release", dec_n, 7);

        // change and inc edges in the same cycle: change wins
        bc = 0;
        bi = 0;
        tick(5);
        chk("tie field_sel", int'(field_sel), 3);
        chk("tie inc_count", inc_n, 2);
        bc = 1;
        bi = 1;
        tick(5);
        chk("tie inc_count released", inc_n, 2);

        // idle timeout from F1
        press_change();
        chk("to run exit_count", exit_n, 3);
        press_change();
        bc = 0;
        tick(5);
        bc = 1;
        chk("timeout field_sel", int'(field_sel), 2);
        tick(51);
        chk("timeout not yet", int'(run_en), 0);
        tick(1);
        chk("timeout run_en", int'(run_en), 1);
        chk("timeout exit_pulse", int'(exit_pulse), 1);
        chk("timeout field_sel0", int'(field_sel), 0);
        tick(1);
        chk("timeout exit single", int'(exit_pulse), 0);
        chk("timeout exit_count", exit_n, 4);

        // reset mid-edit aborts without exit_pulse
        press_change();
        press_change();
        press_change();
        chk("pre-reset field_sel", int'(field_sel), 3);
        chk("pre-reset led17", int'(led17), 1);
        rst = 1;
        tick(1);
        chk("abort run_en", int'(run_en), 1);
        chk("abort field_sel", int'(field_sel), 0);
        chk("abort exit_pulse", int'(exit_pulse), 0);
        chk("abort leds", leds(), 0);
        tick(2);
        rst = 0;
        tick(5);
        chk("abort exit_count", exit_n, 4);
        chk("abort run_en after", int'(run_en), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
